led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_pattern_ctrl_if.sv | 33 +++
 rtl/led_step_timer.sv | 38 +++
 rtl/led_pattern_ctrl.sv | 175 +++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and seed constants for the LED pattern sequencer.
package led_pkg;

    localparam int LED_MAX = 32;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [LED_MAX-1:0] SEED_LOW = {{(LED_MAX-1){1'b0}}, 1'b1};
    localparam logic [LED_MAX-1:0] SEED_ALL = {LED_MAX{1'b1}};

    // Callers truncate the result to their own LED width.
    function automatic logic [LED_MAX-1:0] seed_of(input mode_e mode, input int led_num);
        case (mode)
            MODE_SHR:   seed_of = SEED_LOW << (led_num - 1);
            MODE_BLINK: seed_of = SEED_ALL;
            default:    seed_of = SEED_LOW;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Configuration handshake bundle for led_pattern_ctrl.
// cfg_duty_i exists only when LED_PATTERN_DIM_EN is defined.
interface led_pattern_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [1:0]       cfg_mode_i;
    logic [CNT_W-1:0] cfg_period_i;
`ifdef LED_PATTERN_DIM_EN
    logic [3:0]       cfg_duty_i;
`endif

    modport master (
`ifdef LED_PATTERN_DIM_EN
        output cfg_duty_i,
`endif
        output cfg_valid_i,
        output cfg_mode_i,
        output cfg_period_i,
        input  cfg_ready_o
    );

    modport slave (
`ifdef LED_PATTERN_DIM_EN
        input  cfg_duty_i,
`endif
        input  cfg_valid_i,
        input  cfg_mode_i,
        input  cfg_period_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/led_step_timer.sv
// Step-period counter: counts while running, clears on period-1 and pulses step.
module led_step_timer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK_i,
    input  logic             RSTn_i,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_hit,
    output logic             o_step
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic [CNT_W-1:0] w_last;

    // i_period is never zero here; the parent substitutes 1 for 0.
    assign w_last = i_period - CNT_W'(1);
    assign o_hit  = i_run && (r_cnt == w_last);
    assign o_step = r_step;

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else if (o_hit) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_step <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: IDLE/RUN FSM with step-aligned configuration updates.
// Optional PWM dimming is enabled by defining LED_PATTERN_DIM_EN.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int LED_NUM    = 8,
    parameter int CNT_W      = 32,
    parameter int DEF_PERIOD = 300_000_000
) (
    input  logic               CLK_i,
    input  logic               RSTn_i,
    input  logic               start_i,
    input  logic               stop_i,
    led_pattern_ctrl_if.slave  cfg,
    output logic               busy_o,
    output logic               step_o,
    output logic [LED_NUM-1:0] LED_o
);

    localparam logic [CNT_W-1:0] DEF_EFF = (DEF_PERIOD == 0) ? CNT_W'(1) : CNT_W'(DEF_PERIOD);

    state_e             r_state, w_state_nxt;
    logic               w_start_run, w_stop_run;

    mode_e              r_mode, r_pend_mode;
    logic [CNT_W-1:0]   r_period, r_pend_period;
    logic               r_pend_vld;
    logic [LED_NUM-1:0] r_led;
    logic               r_dir;

    logic               w_in_idle, w_ready, w_acc, w_hit, w_timer_run;
    logic               w_apply_cfg, w_apply_pend, w_hold_cfg;
    mode_e              w_cfg_mode, w_seed_mode;
    logic [CNT_W-1:0]   w_cfg_period;
    logic [LED_NUM-1:0] w_seed, w_adv;
    logic               w_adv_dir;

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Stop wins over start; start in RUN and stop in IDLE are no-ops.
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_stop_run  = 1'b0;
        case (r_state)
            ST_IDLE: if (start_i && !stop_i) begin
                w_state_nxt = ST_RUN;
                w_start_run = 1'b1;
            end
            ST_RUN: if (stop_i) begin
                w_state_nxt = ST_IDLE;
                w_stop_run  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_in_idle       = (r_state == ST_IDLE);
    assign busy_o          = (r_state == ST_RUN);
    assign w_ready         = !r_pend_vld;
    assign cfg.cfg_ready_o = w_ready;
    assign w_acc           = cfg.cfg_valid_i && w_ready;
    assign w_cfg_mode      = mode_e'(cfg.cfg_mode_i);
    assign w_cfg_period    = (cfg.cfg_period_i == '0) ? CNT_W'(1) : cfg.cfg_period_i;
    assign w_timer_run     = (r_state == ST_RUN) && !stop_i;

    // Leaving RUN flushes: a config offered that cycle is taken directly, else the pending one.
    assign w_apply_cfg  = w_acc && (w_in_idle || w_stop_run);
    assign w_apply_pend = r_pend_vld && !w_in_idle && (w_stop_run ? !w_acc : w_hit);
    assign w_hold_cfg   = w_acc && !w_in_idle && !w_stop_run;

    assign w_seed_mode = w_in_idle ? (w_acc ? w_cfg_mode : r_mode) : r_pend_mode;
    assign w_seed      = LED_NUM'(seed_of(w_seed_mode, LED_NUM));

    always_comb begin
        w_adv     = r_led;
        w_adv_dir = r_dir;
        case (r_mode)
            MODE_SHL:   w_adv = (r_led << 1) | (r_led >> (LED_NUM - 1));
            MODE_SHR:   w_adv = (r_led >> 1) | (r_led << (LED_NUM - 1));
            MODE_PING: if (LED_NUM > 1) begin
                if (r_dir) begin
                    w_adv = r_led << 1;
                    if (w_adv[LED_NUM-1]) w_adv_dir = 1'b0;
                end else begin
                    w_adv = r_led >> 1;
                    if (w_adv[0]) w_adv_dir = 1'b1;
                end
            end
            MODE_BLINK: w_adv = ~r_led;
            default:    w_adv = r_led;
        endcase
    end

    led_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK_i    (CLK_i),
        .RSTn_i   (RSTn_i),
        .i_run    (w_timer_run),
        .i_period (r_period),
        .o_hit    (w_hit),
        .o_step   (step_o)
    );

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            r_mode        <= MODE_SHL;
            r_period      <= DEF_EFF;
            r_pend_vld    <= 1'b0;
            r_pend_mode   <= MODE_SHL;
            r_pend_period <= DEF_EFF;
            r_led         <= '0;
            r_dir         <= 1'b1;
        end else begin
            if (w_apply_cfg) begin
                r_mode   <= w_cfg_mode;
                r_period <= w_cfg_period;
            end else if (w_apply_pend) begin
                r_mode   <= r_pend_mode;
                r_period <= r_pend_period;
            end

            if (w_hold_cfg) begin
                r_pend_vld    <= 1'b1;
                r_pend_mode   <= w_cfg_mode;
                r_pend_period <= w_cfg_period;
            end else if (w_apply_pend || w_stop_run) begin
                r_pend_vld    <= 1'b0;
            end

            // A mode change at a boundary restarts from that mode's seed.
            if (w_start_run) begin
                r_led <= w_seed;
                r_dir <= 1'b1;
            end else if (w_stop_run) begin
                r_led <= '0;
                r_dir <= 1'b1;
            end else if (w_hit) begin
                if (w_apply_pend && (r_pend_mode != r_mode)) begin
                    r_led <= w_seed;
                    r_dir <= 1'b1;
                end else begin
                    r_led <= w_adv;
                    r_dir <= w_adv_dir;
                end
            end
        end
    end

`ifdef LED_PATTERN_DIM_EN
    logic [3:0] r_pwm, r_duty, r_pend_duty;

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            r_pwm       <= 4'd0;
            r_duty      <= 4'd15;
            r_pend_duty <= 4'd15;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (w_apply_cfg)       r_duty <= cfg.cfg_duty_i;
            else if (w_apply_pend) r_duty <= r_pend_duty;
            if (w_hold_cfg)        r_pend_duty <= cfg.cfg_duty_i;
        end
    end

    assign LED_o = r_led & {LED_NUM{(r_pwm < r_duty)}};
`else
    assign LED_o = r_led;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (LED_NUM=8), one task per scenario.
module tb_led_pattern_ctrl;

    localparam int LED_NUM = 8;
    localparam int CNT_W   = 32;

    logic               CLK_i   = 1'b0;
    logic               RSTn_i  = 1'b0;
    logic               start_i = 1'b0;
    logic               stop_i  = 1'b0;
    logic               busy_o;
    logic               step_o;
    logic [LED_NUM-1:0] LED_o;

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    led_pattern_ctrl #(
        .LED_NUM    (LED_NUM),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (300_000_000)
    ) dut (
        .CLK_i   (CLK_i),
        .RSTn_i  (RSTn_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .cfg     (cfg_if.slave),
        .busy_o  (busy_o),
        .step_o  (step_o),
        .LED_o   (LED_o)
    );

    always #5 CLK_i = ~CLK_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic cfg_idle(input logic [1:0] m, input logic [CNT_W-1:0] p);
        cfg_if.cfg_valid_i  = 1'b1;
        cfg_if.cfg_mode_i   = m;
        cfg_if.cfg_period_i = p;
        tick();
        cfg_if.cfg_valid_i  = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    task automatic test_reset();
        RSTn_i = 1'b0;
        repeat (2) tick();
        n_checks++; if (LED_o !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", LED_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step_o); end
        n_checks++; if (cfg_if.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready_o); end
        @(negedge CLK_i);
        RSTn_i = 1'b1;
        tick();
        n_checks++; if (busy_o !== 1'b0 || LED_o !== 8'h00) begin n_fail++; $display("FAIL post_reset_idle: busy %b led %h want 0 00", busy_o, LED_o); end
    endtask

    task automatic test_shift_left();
        logic [7:0] tab [8];
        logic [7:0] prev;
        tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        cfg_idle(2'b00, 32'd4);
        pulse_start();
        n_checks++; if (LED_o !== 8'h01 || busy_o !== 1'b1 || step_o !== 1'b0) begin n_fail++; $display("FAIL shl_seed: led %h busy %b step %b want 01 1 0", LED_o, busy_o, step_o); end
        prev = 8'h01;
        for (int k = 0; k < 8; k++) begin
            repeat (3) tick();
            n_checks++; if (LED_o !== prev || step_o !== 1'b0) begin n_fail++; $display("FAIL shl_hold%0d: led %h step %b want %h 0", k, LED_o, step_o, prev); end
            tick();
            n_checks++; if (LED_o !== tab[k] || step_o !== 1'b1) begin n_fail++; $display("FAIL shl_step%0d: led %h step %b want %h 1", k, LED_o, step_o, tab[k]); end
            prev = tab[k];
        end
        pulse_stop();
        n_checks++; if (LED_o !== 8'h00 || busy_o !== 1'b0) begin n_fail++; $display("FAIL shl_stop: led %h busy %b want 00 0", LED_o, busy_o); end
        pulse_stop();
        n_checks++; if (busy_o !== 1'b0 || cfg_if.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL stop_in_idle: busy %b ready %b want 0 1", busy_o, cfg_if.cfg_ready_o); end
    endtask

    task automatic test_ping_pong();
        logic [7:0] tab [16];
        tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        cfg_idle(2'b10, 32'd4);
        pulse_start();
        n_checks++; if (LED_o !== 8'h01) begin n_fail++; $display("FAIL ping_seed: got %h want 01", LED_o); end
        for (int k = 0; k < 16; k++) begin
            repeat (4) tick();
            n_checks++; if (LED_o !== tab[k] || step_o !== 1'b1) begin n_fail++; $display("FAIL ping_step%0d: led %h step %b want %h 1", k, LED_o, step_o, tab[k]); end
        end
        pulse_stop();
    endtask

    task automatic test_cfg_in_run();
        cfg_idle(2'b00, 32'd4);
        pulse_start();
        tick();
        cfg_if.cfg_valid_i  = 1'b1;
        cfg_if.cfg_mode_i   = 2'b01;
        cfg_if.cfg_period_i = 32'd4;
        tick();
        cfg_if.cfg_valid_i  = 1'b0;
        n_checks++; if (cfg_if.cfg_ready_o !== 1'b0 || LED_o !== 8'h01) begin n_fail++; $display("FAIL run_cfg_pending: ready %b led %h want 0 01", cfg_if.cfg_ready_o, LED_o); end
        tick();
        n_checks++; if (cfg_if.cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL run_cfg_ready_low: got %b want 0", cfg_if.cfg_ready_o); end
        tick();
        n_checks++; if (LED_o !== 8'h80 || step_o !== 1'b1 || cfg_if.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL run_cfg_apply: led %h step %b ready %b want 80 1 1", LED_o, step_o, cfg_if.cfg_ready_o); end
        repeat (4) tick();
        n_checks++; if (LED_o !== 8'h40) begin n_fail++; $display("FAIL run_shr: got %h want 40", LED_o); end
        // Same mode, shorter period: advances normally, then steps every 2 cycles.
        cfg_if.cfg_valid_i  = 1'b1;
        cfg_if.cfg_mode_i   = 2'b01;
        cfg_if.cfg_period_i = 32'd2;
        tick();
        cfg_if.cfg_valid_i  = 1'b0;
        n_checks++; if (cfg_if.cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL per_pending: ready %b want 0", cfg_if.cfg_ready_o); end
        repeat (3) tick();
        n_checks++; if (LED_o !== 8'h20 || step_o !== 1'b1 || cfg_if.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL per_apply: led %h step %b ready %b want 20 1 1", LED_o, step_o, cfg_if.cfg_ready_o); end
        tick();
        n_checks++; if (LED_o !== 8'h20 || step_o !== 1'b0) begin n_fail++; $display("FAIL per_hold: led %h step %b want 20 0", LED_o, step_o); end
        tick();
        n_checks++; if (LED_o !== 8'h10 || step_o !== 1'b1) begin n_fail++; $display("FAIL per_step: led %h step %b want 10 1", LED_o, step_o); end
        pulse_stop();
    endtask

    task automatic test_cfg_with_start();
        cfg_if.cfg_valid_i  = 1'b1;
        cfg_if.cfg_mode_i   = 2'b01;
        cfg_if.cfg_period_i = 32'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cfg_if.cfg_valid_i  = 1'b0;
        n_checks++; if (LED_o !== 8'h80 || busy_o !== 1'b1) begin n_fail++; $display("FAIL cfg_start_seed: led %h busy %b want 80 1", LED_o, busy_o); end
        repeat (4) tick();
        n_checks++; if (LED_o !== 8'h40 || step_o !== 1'b1) begin n_fail++; $display("FAIL cfg_start_step: led %h step %b want 40 1", LED_o, step_o); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        cfg_idle(2'b00, 32'd4);
        pulse_start();
        repeat (2) tick();
        pulse_start();
        n_checks++; if (busy_o !== 1'b1 || LED_o !== 8'h01) begin n_fail++; $display("FAIL start_in_run: busy %b led %h want 1 01", busy_o, LED_o); end
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || LED_o !== 8'h00 || step_o !== 1'b0) begin n_fail++; $display("FAIL start_stop_both: busy %b led %h step %b want 0 00 0", busy_o, LED_o, step_o); end
        pulse_start();
        n_checks++; if (busy_o !== 1'b1 || LED_o !== 8'h01) begin n_fail++; $display("FAIL restart: busy %b led %h want 1 01", busy_o, LED_o); end
        pulse_stop();
    endtask

    task automatic test_period_zero();
        logic [7:0] tab [3];
        tab = '{8'h02, 8'h04, 8'h08};
        cfg_idle(2'b00, 32'd0);
        pulse_start();
        n_checks++; if (LED_o !== 8'h01 || step_o !== 1'b0) begin n_fail++; $display("FAIL p0_seed: led %h step %b want 01 0", LED_o, step_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (LED_o !== tab[k] || step_o !== 1'b1) begin n_fail++; $display("FAIL p0_step%0d: led %h step %b want %h 1", k, LED_o, step_o, tab[k]); end
        end
        pulse_stop();
    endtask

    task automatic test_async_reset();
        cfg_idle(2'b11, 32'd4);
        pulse_start();
        n_checks++; if (LED_o !== 8'hFF) begin n_fail++; $display("FAIL blink_seed: got %h want ff", LED_o); end
        repeat (4) tick();
        n_checks++; if (LED_o !== 8'h00 || step_o !== 1'b1) begin n_fail++; $display("FAIL blink_off: led %h step %b want 00 1", LED_o, step_o); end
        repeat (4) tick();
        n_checks++; if (LED_o !== 8'hFF || step_o !== 1'b1) begin n_fail++; $display("FAIL blink_on: led %h step %b want ff 1", LED_o, step_o); end
        tick();
        #2;
        RSTn_i = 1'b0;
        #1;
        n_checks++; if (LED_o !== 8'h00 || busy_o !== 1'b0 || step_o !== 1'b0) begin n_fail++; $display("FAIL async_reset: led %h busy %b step %b want 00 0 0", LED_o, busy_o, step_o); end
        #2;
        RSTn_i = 1'b1;
        #1;
        n_checks++; if (cfg_if.cfg_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL after_reset: ready %b busy %b want 1 0", cfg_if.cfg_ready_o, busy_o); end
        tick();
    endtask

    initial begin
        cfg_if.cfg_valid_i  = 1'b0;
        cfg_if.cfg_mode_i   = 2'b00;
        cfg_if.cfg_period_i = '0;
`ifdef LED_PATTERN_DIM_EN
        cfg_if.cfg_duty_i   = 4'd15;
`endif
        test_reset();
        test_shift_left();
        test_ping_pong();
        test_cfg_in_run();
        test_cfg_with_start();
        test_back_to_back();
        test_period_zero();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
